// File: rtl/div_seq_signed.sv
// div_seq_signed: multi-cycle signed restoring divider, one quotient bit per cycle.
// Divides the numerator magnitude by an unsigned divisor and reapplies the numerator sign at the end.
module div_seq_signed #(
    parameter int NUM_W = 16,
    parameter int DIV_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NUM_W-1:0] quot_o,
    output logic [NUM_W-1:0] rem_o,
    output logic             div_zero_o
);
    localparam int CW = $clog2(NUM_W);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [NUM_W-1:0] mag_q, mag_d, quot_q, quot_d, rem_o_q, rem_o_d;
    logic [NUM_W-1:0] step_mag, rem_ext;
    logic [DIV_W:0]   rem_q, rem_d, shift_rem, step_rem;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sign_q, sign_d, dz_q, dz_d, ge;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mag_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            quot_q  <= '0;
            rem_o_q <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            quot_q  <= quot_d;
            rem_o_q <= rem_o_d;
            dz_q    <= dz_d;
        end
    end
    // The partial remainder stays below the divisor, so its top bit is free before each shift.
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        rem_d     = rem_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        quot_d    = quot_q;
        rem_o_d   = rem_o_q;
        dz_d      = dz_q;
        shift_rem = {rem_q[DIV_W-1:0], mag_q[NUM_W-1]};
        ge        = shift_rem >= {1'b0, div_q};
        step_rem  = ge ? shift_rem - {1'b0, div_q} : shift_rem;
        step_mag  = {mag_q[NUM_W-2:0], ge};
        rem_ext   = {{(NUM_W-DIV_W-1){1'b0}}, step_rem};
        case (state_q)
            IDLE: if (in_valid) begin
                mag_d  = num_i[NUM_W-1] ? -num_i : num_i;
                sign_d = num_i[NUM_W-1];
                div_d  = div_i;
                rem_d  = '0;
                cnt_d  = CW'(NUM_W-1);
                if (div_i == '0) begin
                    state_d = DONE;
                    quot_d  = '0;
                    rem_o_d = num_i;
                    dz_d    = 1'b1;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                mag_d = step_mag;
                rem_d = step_rem;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quot_d  = sign_q ? -step_mag : step_mag;
                    rem_o_d = sign_q ? -rem_ext : rem_ext;
                end
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
                dz_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign quot_o     = quot_q;
    assign rem_o      = rem_o_q;
    assign div_zero_o = dz_q;
endmodule

// File: tb/tb_div_seq_signed.sv
// tb_div_seq_signed: scoreboard bench for div_seq_signed against C-style / and % on ints.
module tb_div_seq_signed;
    localparam int NW = 16;
    localparam int DW = 5;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, div_zero_o;
    logic [NW-1:0] num_i = '0;
    logic [NW-1:0] quot_o, rem_o;
    logic [DW-1:0] div_i = '0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            rand_rdy = 1'b0;
    typedef struct packed { int q; int r; bit dz; } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    div_seq_signed #(.NUM_W(NW), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .num_i(num_i), .div_i(div_i), .out_valid(out_valid), .out_ready(out_ready),
        .quot_o(quot_o), .rem_o(rem_o), .div_zero_o(div_zero_o)
    );

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    function automatic exp_t model(input logic [NW-1:0] n, input logic [DW-1:0] d);
        int   ni = int'($signed(n));
        int   di = int'(d);
        exp_t e;
        if (di == 0) begin
            e.q = 0; e.r = ni; e.dz = 1'b1;
        end else begin
            e.q = ni / di; e.r = ni % di; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every completed output handshake consumes exactly one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (!out_valid) chk("dz_without_valid", int'(div_zero_o), 0);
            if (out_valid && out_ready) begin
                chk("result_expected", int'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("quot", int'($signed(quot_o)), e.q);
                    chk("rem", int'($signed(rem_o)), e.r);
                    chk("div_zero", int'(div_zero_o), int'(e.dz));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1);
    end

    task automatic send(input logic [NW-1:0] n, input logic [DW-1:0] d);
        int guard = 0;
        in_valid = 1'b1; num_i = n; div_i = d;
        @(negedge clk);
        while (!in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_in_time", int'(in_ready), 1);
        if (in_ready) sb_q.push_back(model(n, d));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic op_lat(input logic [NW-1:0] n, input logic [DW-1:0] d, input int want_lat);
        int lat = 0;
        send(n, d);
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        chk("latency", lat, want_lat);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            g;
        logic [NW-1:0] hq, hr;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quot_o), 0);
        chk("rst_rem", int'(rem_o), 0);
        chk("rst_div_zero", int'(div_zero_o), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        op_lat(16'd169, 5'd13, NW + 1);
        op_lat(-16'sd27, 5'd13, NW + 1);
        op_lat(16'd27, 5'd13, NW + 1);
        op_lat(-16'sd13, 5'd13, NW + 1);
        op_lat(16'd0, 5'd7, NW + 1);
        op_lat(16'd100, 5'd0, 1);
        op_lat(16'h8000, 5'd1, NW + 1);
        op_lat(16'h7fff, 5'd31, NW + 1);
        op_lat(16'h8000, 5'd0, 1);
        // Back-pressure: hold the result for 10 cycles with a second request already waiting.
        out_ready = 1'b0;
        send(16'd1000, 5'd9);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 100);
        chk("bp_valid", int'(out_valid), 1);
        hq = quot_o;
        hr = rem_o;
        in_valid = 1'b1; num_i = -16'sd50; div_i = 5'd7;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold_quot", int'(quot_o), int'(hq));
            chk("bp_hold_rem", int'(rem_o), int'(hr));
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_in_ready", int'(in_ready), 1);
        chk("bp_idle_out_valid", int'(out_valid), 0);
        send(-16'sd50, 5'd7);
        drain();
        // Reset in the fifth CALC cycle discards the operation.
        send(16'd300, 5'd7);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        chk("mid_rst_in_ready", int'(in_ready), 1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_quot", int'(quot_o), 0);
        send(16'd50, 5'd7);
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            int            sel;
            logic [NW-1:0] n;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            sel = $urandom_range(0, 7);
            n = sel == 0 ? 16'h8000 : sel == 1 ? 16'h7fff : NW'($urandom);
            send(n, DW'($urandom_range(0, 31)));
        end
        drain();
        rand_rdy = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
